sub_bytes_iter: RTL



---
 rtl/sub_bytes_iter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes over a 128-bit state, LANES bytes per cycle, valid/ready on both sides.
// Define SUB_BYTES_SHIFT_ROWS_EN to fuse ShiftRows into the final write of the result.
module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int CHUNKS = 16 / LANES;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
            $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           st;
    state_e           st_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_chunk;
    logic [7:0]       work     [16];
    logic [7:0]       work_sub [16];
    logic [7:0]       work_fin [16];
    logic [3:0]       lane_sel [LANES];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Byte S-box: multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign last_chunk = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (in_valid) st_nxt = BUSY;
            BUSY:    if (last_chunk) st_nxt = DONE;
            DONE:    if (out_ready) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (st == IDLE);
        busy      = (st == BUSY);
        out_valid = (st == DONE);
        state_out = '0;
        for (int i = 0; i < 16; i++) state_out[127-8*i -: 8] = work[i];
    end

    // Only the LANES bytes of the current chunk pass through an S-box each cycle.
    always_comb begin
        work_sub = work;
        for (int l = 0; l < LANES; l++) begin
            lane_sel[l] = 4'(int'(cnt) * LANES + l);
            work_sub[lane_sel[l]] = sbox(work[lane_sel[l]]);
        end
    end

    always_comb begin
        work_fin = work_sub;
`ifdef SUB_BYTES_SHIFT_ROWS_EN
        // Row r of the result is row r of the substituted state rotated left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                work_fin[4*c+r] = work_sub[4*((c+r)%4)+r];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < 16; i++) work[i] <= 8'h00;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        cnt <= '0;
                        for (int i = 0; i < 16; i++) work[i] <= state_in[127-8*i -: 8];
                    end
                end
                BUSY: begin
                    if (last_chunk) begin
                        cnt  <= '0;
                        work <= work_fin;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        work <= work_sub;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
